io_pinmux_ctrl: RTL

- Pin-multiplexing controller between NUM_FUNC on-chip peripheral functions and NUM_PADS tri-state full pads (tc_io_tri_full_pad instances).
- Holds per-pad function select and pad config (cs/pu/pd), and synchronises pad inputs.
- Reconfigures a pad with a break-before-make sequence (drain, switch, settle) so two functions never drive a pad together and no function sees an input glitch.
- Sits between the peripheral cluster and the pad ring; configured by the SoC register file.

---
 rtl/io_pinmux_pkg.sv | 29 ++
 rtl/io_sync2.sv | 24 ++
 rtl/io_pinmux_ctrl.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/io_pinmux_pkg.sv
// Shared types for the pad multiplexer: sequencer states and the per-pad
// configuration record.
package io_pinmux_pkg;

  localparam int FSEL_MAX_W = 8;

  typedef enum logic [1:0] {
    IDLE,
    DRAIN,
    SWITCH,
    SETTLE
  } pinmux_state_e;

  typedef struct packed {
    logic [FSEL_MAX_W-1:0] fsel;
    logic                  cs;
    logic                  pu;
    logic                  pd;
  } pad_cfg_t;

  localparam pad_cfg_t PAD_CFG_RST = '{fsel: '0, cs: 1'b1, pu: 1'b0, pd: 1'b0};

  // Pull-down wins when both pulls are requested.
  function automatic pad_cfg_t make_cfg(input logic [FSEL_MAX_W-1:0] fsel,
                                        input logic cs, input logic pu, input logic pd);
    make_cfg = '{fsel: fsel, cs: cs, pu: pu & ~pd, pd: pd};
  endfunction

endpackage

// File: rtl/io_sync2.sv
// Two-flop synchroniser for one asynchronous pad input.
module io_sync2 (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      r_meta <= d_i;
      r_sync <= r_meta;
    end
  end

  assign q_o = r_sync;

endmodule

// File: rtl/io_pinmux_ctrl.sv
// Pad multiplexer: per-pad function select and pad config, reconfigured with a
// drain / switch / settle sequence so a pad never sees two drivers or glitches.
module io_pinmux_ctrl
  import io_pinmux_pkg::*;
#(
  parameter int NUM_PADS  = 8,
  parameter int NUM_FUNC  = 4,
  parameter int GUARD_CYC = 4
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          cfg_we_i,
  input  logic [$clog2(NUM_PADS)-1:0]   cfg_idx_i,
  input  logic [$clog2(NUM_FUNC)-1:0]   cfg_fsel_i,
  input  logic                          cfg_cs_i,
  input  logic                          cfg_pu_i,
  input  logic                          cfg_pd_i,
  output logic                          cfg_ready_o,
  output logic                          cfg_done_o,
  output logic                          cfg_err_o,
  input  logic [NUM_FUNC*NUM_PADS-1:0]  func_c2p_i,
  input  logic [NUM_FUNC*NUM_PADS-1:0]  func_oe_i,
  output logic [NUM_FUNC*NUM_PADS-1:0]  func_p2c_o,
  output logic [NUM_PADS-1:0]           pad_c2p_o,
  output logic [NUM_PADS-1:0]           pad_c2p_en_o,
  input  logic [NUM_PADS-1:0]           pad_p2c_i,
  output logic [NUM_PADS-1:0]           pad_cs_o,
  output logic [NUM_PADS-1:0]           pad_pu_o,
  output logic [NUM_PADS-1:0]           pad_pd_o
);

  localparam int IW = $clog2(NUM_PADS);
  localparam int FW = $clog2(NUM_FUNC);
  localparam int CW = $clog2(GUARD_CYC) + 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(GUARD_CYC - 1);

  pinmux_state_e r_state;
  pinmux_state_e w_state_next;
  logic [CW-1:0] r_cnt;
  logic [IW-1:0] r_pend_idx;
  pad_cfg_t      r_pend_cfg;
  pad_cfg_t      r_cfg [NUM_PADS];
  logic          r_done;
  logic          r_err;

  pad_cfg_t            w_new_cfg;
  pad_cfg_t            w_cur_cfg;
  logic                w_accept;
  logic                w_invalid;
  logic                w_noop;
  logic                w_start;
  logic                w_busy;
  logic                w_switch;
  logic [NUM_PADS-1:0] w_mask;
  logic [NUM_PADS-1:0] w_sync;

  assign w_accept  = cfg_we_i & cfg_ready_o;
  assign w_new_cfg = make_cfg(FSEL_MAX_W'(cfg_fsel_i), cfg_cs_i, cfg_pu_i, cfg_pd_i);
  assign w_invalid = ({1'b0, cfg_fsel_i} >= (FW+1)'(NUM_FUNC)) |
                     ({1'b0, cfg_idx_i}  >= (IW+1)'(NUM_PADS));

  always_comb begin
    w_cur_cfg = PAD_CFG_RST;
    for (int p = 0; p < NUM_PADS; p++) begin
      if (cfg_idx_i == IW'(p)) w_cur_cfg = r_cfg[p];
    end
  end

  assign w_noop  = ~w_invalid & (w_cur_cfg == w_new_cfg);
  assign w_start = w_accept & ~w_invalid & ~w_noop;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) r_state <= IDLE;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (w_start) w_state_next = DRAIN;
      DRAIN:   if (r_cnt == '0) w_state_next = SWITCH;
      SWITCH:  w_state_next = SETTLE;
      SETTLE:  if (r_cnt == '0) w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_comb begin
    cfg_ready_o = (r_state == IDLE);
    w_busy      = (r_state != IDLE);
    w_switch    = (r_state == SWITCH);
  end

  // The same counter times both guard phases; it is reloaded on SWITCH.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_cnt      <= '0;
      r_pend_idx <= '0;
      r_pend_cfg <= PAD_CFG_RST;
    end else if (w_start) begin
      r_cnt      <= CNT_LOAD;
      r_pend_idx <= cfg_idx_i;
      r_pend_cfg <= w_new_cfg;
    end else if (w_switch) begin
      r_cnt <= CNT_LOAD;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - CW'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int p = 0; p < NUM_PADS; p++) r_cfg[p] <= PAD_CFG_RST;
    end else if (w_switch) begin
      for (int p = 0; p < NUM_PADS; p++) begin
        if (r_pend_idx == IW'(p)) r_cfg[p] <= r_pend_cfg;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
    end else begin
      r_done <= (w_accept & w_noop) | ((r_state == SETTLE) & (r_cnt == '0));
      r_err  <= w_accept & w_invalid;
    end
  end

  assign cfg_done_o = r_done;
  assign cfg_err_o  = r_err;

  generate
    for (genvar gi = 0; gi < NUM_PADS; gi++) begin : g_pad
      logic [NUM_FUNC-1:0] w_c2p_col;
      logic [NUM_FUNC-1:0] w_oe_col;

      io_sync2 u_sync (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .d_i   (pad_p2c_i[gi]),
        .q_o   (w_sync[gi])
      );

      assign w_mask[gi] = w_busy & (r_pend_idx == IW'(gi));

      for (genvar gj = 0; gj < NUM_FUNC; gj++) begin : g_func
        logic w_sel;
        assign w_sel = (r_cfg[gi].fsel == FSEL_MAX_W'(gj));
        assign w_c2p_col[gj] = w_sel & func_c2p_i[gj*NUM_PADS+gi];
        assign w_oe_col[gj]  = w_sel & func_oe_i[gj*NUM_PADS+gi];
        assign func_p2c_o[gj*NUM_PADS+gi] = w_sel & ~w_mask[gi] & w_sync[gi];
      end

      assign pad_c2p_o[gi]    = |w_c2p_col;
      assign pad_c2p_en_o[gi] = (|w_oe_col) & ~w_mask[gi];
      assign pad_cs_o[gi]     = r_cfg[gi].cs;
      assign pad_pu_o[gi]     = r_cfg[gi].pu;
      assign pad_pd_o[gi]     = r_cfg[gi].pd;
    end
  endgenerate

endmodule
